// File: rtl/mul_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
// Imported by the controller and by anything that inspects its state.
package mul_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;
  localparam int CNT_W  = 5;

  localparam logic [CNT_W-1:0] LAST_STEP = 5'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder32.sv
// 32-bit ripple-carry adder built from full_adder cells.
// couts exposes every stage carry-out; couts[31] is the final carry.
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic [31:0] couts
);

  logic [32:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 32; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign couts = carry[32:1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder, the cell of the ripple-carry adder32.
// Purely combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/shift_add_mul16.sv
// Multi-cycle unsigned 16x16 multiplier: sequences one adder32
// through a shift-and-add loop with valid/ready on both sides.
module shift_add_mul16
  import mul_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b0,
  parameter int OP_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*OP_W-1:0] product,
  output logic              busy
);

  if (OP_W != 16) begin : g_bad_width
    $error("shift_add_mul16: OP_W must be 16");
  end

  state_t state, state_nx;

  logic [PROD_W-1:0] acc, acc_nx;
  logic [PROD_W-1:0] mcand, mcand_nx;
  logic [OP_W-1:0]   mplier, mplier_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;

  logic [PROD_W-1:0] addend;
  logic [PROD_W-1:0] sum;
  logic [PROD_W-1:0] couts;
  logic              carry_top;
  logic              unused_carries;
  logic              last_step;

  assign addend = mplier[0] ? mcand : '0;

  adder32 u_add (
    .a     (acc),
    .b     (addend),
    .cin   (1'b0),
    .sum   (sum),
    .couts (couts)
  );

  // Final carry must stay low: a 16x16 product never overflows 32 bits.
  assign carry_top      = couts[31];
  assign unused_carries = ^couts[30:0];

  assign last_step = (cnt == LAST_STEP) ||
                     (EARLY_EXIT && ((mplier >> 1) == '0));

  always_comb begin
    state_nx  = state;
    acc_nx    = acc;
    mcand_nx  = mcand;
    mplier_nx = mplier;
    cnt_nx    = cnt;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          acc_nx    = '0;
          mcand_nx  = {{OP_W{1'b0}}, a};
          mplier_nx = b;
          cnt_nx    = '0;
          if (EARLY_EXIT && (b == '0)) state_nx = DONE;
          else                         state_nx = RUN;
        end
      end
      RUN: begin
        acc_nx    = sum;
        mcand_nx  = mcand << 1;
        mplier_nx = mplier >> 1;
        cnt_nx    = cnt + 5'd1;
        if (last_step) state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nx;
      acc    <= acc_nx;
      mcand  <= mcand_nx;
      mplier <= mplier_nx;
      cnt    <= cnt_nx;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign product   = acc;

endmodule

// File: tb/tb_shift_add_mul16.sv
// Randomized bench for shift_add_mul16 with both EARLY_EXIT settings,
// checked against an arithmetic latency/product model.
module tb_shift_add_mul16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_ready = 1'b1;
  int          cur = 0;

  logic        iv0, ir0, ov0, bz0;
  logic        iv1, ir1, ov1, bz1;
  logic [31:0] p0, p1;

  logic        s_ready, s_valid, s_busy, s_carry;
  logic [31:0] s_prod;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign iv0 = in_valid && (cur == 0);
  assign iv1 = in_valid && (cur == 1);

  shift_add_mul16 #(.EARLY_EXIT(1'b0)) u0 (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0),
    .a(a), .b(b), .out_valid(ov0), .out_ready(out_ready),
    .product(p0), .busy(bz0)
  );

  shift_add_mul16 #(.EARLY_EXIT(1'b1)) u1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1),
    .a(a), .b(b), .out_valid(ov1), .out_ready(out_ready),
    .product(p1), .busy(bz1)
  );

  assign s_ready = cur ? ir1 : ir0;
  assign s_valid = cur ? ov1 : ov0;
  assign s_busy  = cur ? bz1 : bz0;
  assign s_prod  = cur ? p1 : p0;
  assign s_carry = cur ? u1.carry_top : u0.carry_top;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ref_lat(input bit ee, input logic [15:0] y);
    int hi;
    if (!ee) return 16;
    if (y == 0) return 0;
    hi = 0;
    for (int i = 0; i < 16; i++) if (y[i]) hi = i;
    return hi + 1;
  endfunction

  task automatic accept(input logic [15:0] x, input logic [15:0] y);
    int k = 0;
    while (!s_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("in_ready_before_accept", 32'(s_ready), 32'd1);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  // Assumes accept() was just called; tracks until the handshake.
  task automatic finish(input logic [15:0] x, input logic [15:0] y,
                        input int hold);
    int  n = 0;
    bit  carry_ok = 1'b1;
    bit  ready_ok = 1'b1;
    logic [31:0] exp_p = 32'(x) * 32'(y);
    out_ready = (hold == 0);
    while (!s_valid && n < 40) begin
      if (s_carry !== 1'b0) carry_ok = 1'b0;
      if (s_ready !== 1'b0) ready_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    if (!s_valid) begin
      chk("valid_timeout", 32'(s_valid), 32'd1);
      out_ready = 1'b1;
      return;
    end
    chk("latency", 32'(n), 32'(ref_lat(cur == 1, y)));
    chk("product", s_prod, exp_p);
    chk("carry31_low", 32'(carry_ok), 32'd1);
    chk("in_ready_low_run", 32'(ready_ok), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(s_valid), 32'd1);
      chk("bp_product", s_prod, exp_p);
      chk("bp_in_ready", 32'(s_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_valid", 32'(s_valid), 32'd0);
    chk("post_hs_ready", 32'(s_ready), 32'd1);
  endtask

  task automatic op(input logic [15:0] x, input logic [15:0] y,
                    input int hold);
    accept(x, y);
    finish(x, y, hold);
  endtask

  initial begin
    logic [15:0] x, y;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      cur = d;
      #0;
      chk("rst_in_ready", 32'(s_ready), 32'd1);
      chk("rst_out_valid", 32'(s_valid), 32'd0);
      chk("rst_busy", 32'(s_busy), 32'd0);
      chk("rst_product", s_prod, 32'd0);
    end
    reset = 1'b0;

    cur = 0;
    op(16'd3, 16'd5, 0);
    op(16'hFFFF, 16'hFFFF, 0);
    op(16'd100, 16'd200, 5);

    // Abort mid-run, then confirm no residue leaks into a new result.
    accept(16'd1234, 16'd5678);
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_in_ready", 32'(s_ready), 32'd1);
    chk("abort_out_valid", 32'(s_valid), 32'd0);
    chk("abort_busy", 32'(s_busy), 32'd0);
    op(16'd2, 16'd3, 0);

    cur = 1;
    #1;
    op(16'd7, 16'd1, 0);
    op(16'd9, 16'd0, 0);
    op(16'hFFFF, 16'hFFFF, 0);
    op(16'd100, 16'd200, 3);

    for (int d = 0; d < 2; d++) begin
      cur = d;
      #1;
      for (int i = 0; i < 20; i++) begin
        x = 16'($urandom);
        y = 16'($urandom) >> $urandom_range(0, 16);
        op(x, y, int'($urandom_range(0, 2)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
